decoder_nxm_scan: RTL and testbench
===================================

Name: decoder_nxm_scan

Overview:
- Parametrised registered decoder from SEL_W bits to 2**SEL_W active-low outputs.
- Successor to the combinational 3x8 active-low decoder, with the same output index mapping.
- Adds a valid/ready select interface, an output hold register, and a timed scan mode that walks the active line across every output.
- Sits between control logic and row/bank/strobe select lines.

Parameters:
- SEL_W, 3, select width; derived OUT_W = 2**SEL_W outputs.
- DWELL_W, 4, width of the scan dwell count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  global enable; low forces all outputs inactive.
- sel_valid  in  1  select request valid.
- sel_ready  out  1  block can accept a select.
- sel  in  SEL_W  select code.
- mode  in  1  0 = direct decode, 1 = scan; sampled with sel.
- dwell  in  DWELL_W  scan: extra cycles each position is held; sampled with sel.
- out_n  out  OUT_W  active-low one-hot decoded outputs, registered.
- busy  out  1  high while scanning.
- scan_done  out  1  one-cycle pulse when a full scan pass completes.

Behaviour:
- Mapping: for code c, bit index OUT_W-1-c of out_n is 0 and all other bits are 1.
  - SEL_W=3: c=7 drives out_n[0] low; c=0 drives out_n[7] low.
- Reset (rst_n=0 at an edge):
  - Next cycle: out_n = all ones, busy=0, scan_done=0, state IDLE.
  - Internal pointer, dwell counter and latched dwell all cleared.
  - Applies mid-scan too; no scan_done is issued.
- sel_ready = en AND state != SCAN. This is combinational from state and en.
- Accept = sel_valid AND sel_ready at a rising edge.
- States: IDLE, HOLD, SCAN.
- IDLE: out_n = all ones.
  - Accept with mode=0: next cycle out_n decodes sel (1-cycle latency); go to HOLD.
  - Accept with mode=1: go to SCAN (see below).
- HOLD: out_n holds the last decoded value.
  - A new accept updates out_n next cycle. Back-to-back accepts give one update per cycle.
  - Accept with mode=1 enters SCAN.
- SCAN entry:
  - Pointer p = sel; latch D = dwell.
  - Next cycle: out_n decodes p, busy=1.
- SCAN stepping:
  - Each position is held D+1 cycles (D=0 means advance every cycle).
  - p then increments modulo OUT_W; it wraps from OUT_W-1 to 0.
  - One pass covers OUT_W positions starting at sel: exactly OUT_W*(D+1) cycles with busy=1.
- SCAN completion:
  - On the cycle after the last position's final dwell cycle: out_n = all ones, busy=0, scan_done=1 for one cycle, state IDLE.
  - sel_ready rises the same cycle, so a new accept is possible the cycle after.
- en=0 at an edge, in any state:
  - Next cycle: out_n = all ones, busy=0, state IDLE.
  - An active scan is aborted without scan_done.
  - No accepts while en=0.
- sel_valid while sel_ready=0: ignored and not queued. The requester must hold sel_valid.
- At most one out_n bit is low in any cycle; out_n is never multi-hot.

Optional Feature:
- Macro: DECODER_SCAN_MODE_EN.
- Defined: full behaviour as above.
- Undefined:
  - The SCAN state, pointer and dwell logic are not compiled.
  - mode and dwell are ignored; every accept is a direct decode.
  - busy and scan_done are tied to 0; sel_ready = en.
  - Port list is unchanged.

Test Plan:
- Reset: SEL_W=3, en=1, rst_n=0 for 2 edges -> out_n=8'hFF, busy=0, scan_done=0, sel_ready=1.
- Direct decode: accept sel=0, then 7, then 5 (mode=0) -> out_n 8'h7F, 8'hFE, 8'hFB, each 1 cycle after its accept.
- Back-to-back: accept sel=3 then sel=4 on consecutive edges -> out_n 8'hEF then 8'hF7; hold 8'hF7 with sel_valid=0.
- Scan:
  - Stimulus: accept sel=6, dwell=1, mode=1.
  - out_n sequence, 2 cycles each: 8'hFD, 8'hFE, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB.
  - busy=1 and sel_ready=0 for 16 cycles, then scan_done pulses once with out_n=8'hFF.
  - A sel_valid asserted during the scan is not accepted.
- Abort: en=0 on the 5th scan cycle -> next cycle out_n=8'hFF, busy=0, no scan_done ever; en=1 restores sel_ready=1.
- Reset mid-scan: rst_n=0 on the 3rd scan cycle -> next cycle out_n=8'hFF, busy=0, no scan_done. Rerun with DECODER_SCAN_MODE_EN undefined: a mode=1 accept of sel=2 gives out_n=8'hDF with busy=0.

Source files
------------

// File: rtl/decoder_nxm_scan.sv
// Registered SEL_W-to-2**SEL_W active-low decoder with a valid/ready select port.
// Defining DECODER_SCAN_MODE_EN adds a timed scan that walks the active line across every output.
module decoder_nxm_scan #(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 4,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out_n,
  output logic               busy,
  output logic               scan_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef DECODER_SCAN_MODE_EN
  localparam logic [1:0] ST_SCAN = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] out_n_q, out_n_d;
  logic             accept;

  // Code c pulls line OUT_W-1-c low, which is exactly the bitwise complement of c.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] code);
    logic [OUT_W-1:0] lines;
    logic [SEL_W-1:0] idx;
    lines      = '1;
    idx        = ~code;
    lines[idx] = 1'b0;
    return lines;
  endfunction

  assign out_n = out_n_q;

`ifdef DECODER_SCAN_MODE_EN

  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   pos_q, pos_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  assign sel_ready = en && (state_q != ST_SCAN);
  assign accept    = sel_valid && sel_ready;
  assign busy      = busy_q;
  assign scan_done = done_q;

  // pos_q counts positions already visited so the pass ends after OUT_W of them,
  // independent of where the pointer started.
  always_comb begin
    state_d = state_q;
    out_n_d = out_n_q;
    ptr_d   = ptr_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      out_n_d = '1;
      busy_d  = 1'b0;
    end else if (state_q == ST_SCAN) begin
      if (cnt_q != dwell_q) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pos_q == '1) begin
        state_d = ST_IDLE;
        out_n_d = '1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        cnt_d   = '0;
        pos_d   = pos_q + 1'b1;
        ptr_d   = ptr_q + 1'b1;
        out_n_d = decode(ptr_q + 1'b1);
      end
    end else if (accept) begin
      if (mode) begin
        state_d = ST_SCAN;
        ptr_d   = sel;
        pos_d   = '0;
        cnt_d   = '0;
        dwell_d = dwell;
        busy_d  = 1'b1;
        out_n_d = decode(sel);
      end else begin
        state_d = ST_HOLD;
        out_n_d = decode(sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`else

  // Without scan support mode and dwell have no effect on the decode.
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{mode, dwell};

  assign sel_ready = en;
  assign accept    = sel_valid && sel_ready;
  assign busy      = 1'b0;
  assign scan_done = 1'b0;

  always_comb begin
    state_d = state_q;
    out_n_d = out_n_q;
    if (!en) begin
      state_d = ST_IDLE;
      out_n_d = '1;
    end else if (accept) begin
      state_d = ST_HOLD;
      out_n_d = decode(sel);
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_n_q <= '1;
    end else begin
      state_q <= state_d;
      out_n_q <= out_n_d;
    end
  end

endmodule

// File: tb/tb_decoder_nxm_scan.sv
// Self-checking bench for decoder_nxm_scan: directed plan steps followed by random traffic,
// all checked against a cycle-level behavioural model (follows DECODER_SCAN_MODE_EN).
module tb_decoder_nxm_scan;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;
  localparam int OUT_W   = 8;
`ifdef DECODER_SCAN_MODE_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out_n;
  logic               busy;
  logic               scan_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: a scan is described by its start code, dwell and elapsed cycle count.
  bit         m_scanning = 1'b0;
  bit         m_busy     = 1'b0;
  bit         m_done     = 1'b0;
  logic [7:0] m_out      = 8'hFF;
  int         m_start    = 0;
  int         m_d        = 0;
  int         m_elapsed  = 0;

`ifdef DECODER_SCAN_MODE_EN
  logic [7:0] scan_seq [8] = '{8'hFD, 8'hFE, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB};
`endif

  decoder_nxm_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel       (sel),
    .mode      (mode),
    .dwell     (dwell),
    .out_n     (out_n),
    .busy      (busy),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec(input int c);
    return 8'hFF ^ (8'd1 << (7 - c));
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    acc    = sel_valid && en && !m_scanning;
    m_done = 1'b0;
    if (!rst_n || !en) begin
      m_scanning = 1'b0;
      m_out      = 8'hFF;
      m_busy     = 1'b0;
    end else if (m_scanning) begin
      m_elapsed++;
      if (m_elapsed == OUT_W * (m_d + 1)) begin
        m_scanning = 1'b0;
        m_out      = 8'hFF;
        m_busy     = 1'b0;
        m_done     = 1'b1;
      end else begin
        m_out = dec((m_start + m_elapsed / (m_d + 1)) % OUT_W);
      end
    end else if (acc) begin
      if (mode && SCAN_EN) begin
        m_scanning = 1'b1;
        m_start    = int'(sel);
        m_d        = int'(dwell);
        m_elapsed  = 0;
        m_busy     = 1'b1;
      end
      m_out = dec(int'(sel));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".out_n"}, 32'(out_n), 32'(m_out));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".scan_done"}, 32'(scan_done), 32'(m_done));
    check({tag, ".sel_ready"}, 32'(sel_ready), 32'(en && !m_scanning));
    check({tag, ".onehot"}, 32'($countones(~out_n) <= 1), 32'd1);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v,
                               input logic [SEL_W-1:0] s, input bit md,
                               input logic [DWELL_W-1:0] dw);
    rst_n     = r;
    en        = e;
    sel_valid = v;
    sel       = s;
    mode      = md;
    dwell     = dw;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    sel_valid = 1'b0;
    sel       = '0;
    mode      = 1'b0;
    dwell     = '0;

    // Reset held for two edges.
    applyStimulus(0, 1, 0, 3'd0, 0, 4'd0);
    applyStimulus(0, 1, 0, 3'd0, 0, 4'd0);
    checkOutput("reset");
    check("reset_out", 32'(out_n), 32'hFF);
    check("reset_ready", 32'(sel_ready), 32'd1);

    // Direct decodes, each visible one cycle after its accept.
    applyStimulus(1, 1, 1, 3'd0, 0, 4'd0);
    checkOutput("dir0");
    check("dir0_const", 32'(out_n), 32'h7F);
    applyStimulus(1, 1, 1, 3'd7, 0, 4'd0);
    checkOutput("dir7");
    check("dir7_const", 32'(out_n), 32'hFE);
    applyStimulus(1, 1, 1, 3'd5, 0, 4'd0);
    checkOutput("dir5");
    check("dir5_const", 32'(out_n), 32'hFB);

    // Back-to-back accepts, then hold with sel_valid low.
    applyStimulus(1, 1, 1, 3'd3, 0, 4'd0);
    check("b2b3_const", 32'(out_n), 32'hEF);
    applyStimulus(1, 1, 1, 3'd4, 0, 4'd0);
    check("b2b4_const", 32'(out_n), 32'hF7);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 3'd1, 0, 4'd0);
      checkOutput("hold");
      check("hold_const", 32'(out_n), 32'hF7);
    end

    // Scan from 6 with dwell 1; a competing request stays asserted throughout.
    applyStimulus(1, 1, 1, 3'd6, 1, 4'd1);
    checkOutput("scan_k0");
`ifdef DECODER_SCAN_MODE_EN
    check("scan_k0_const", 32'(out_n), 32'(scan_seq[0]));
`endif
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1, 1, 1, 3'd0, 0, 4'd0);
      checkOutput("scan_step");
`ifdef DECODER_SCAN_MODE_EN
      check("scan_seq_const", 32'(out_n), 32'(scan_seq[k / 2]));
      check("scan_busy_const", 32'(busy), 32'd1);
`endif
    end
    applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
    checkOutput("scan_end");
`ifdef DECODER_SCAN_MODE_EN
    check("scan_done_const", 32'(scan_done), 32'd1);
    check("scan_end_out", 32'(out_n), 32'hFF);
`endif
    applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
    checkOutput("scan_after");

    // Abort with en low on the fifth scan cycle.
    applyStimulus(1, 1, 1, 3'd1, 1, 4'd2);
    checkOutput("abort_k1");
    for (int k = 2; k < 5; k++) begin
      applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
      checkOutput("abort_run");
    end
    applyStimulus(1, 0, 0, 3'd0, 0, 4'd0);
    checkOutput("abort");
    check("abort_out", 32'(out_n), 32'hFF);
    check("abort_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1, 3'd2, 0, 4'd0);
      checkOutput("abort_en_low");
    end
    applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
    check("abort_ready", 32'(sel_ready), 32'd1);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
      checkOutput("abort_quiet");
    end

    // Reset on the third scan cycle.
    applyStimulus(1, 1, 1, 3'd3, 1, 4'd3);
    checkOutput("rst_k1");
    applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
    checkOutput("rst_k2");
    applyStimulus(0, 1, 0, 3'd0, 0, 4'd0);
    checkOutput("rst_mid");
    check("rst_mid_out", 32'(out_n), 32'hFF);
    check("rst_mid_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1, 1, 0, 3'd0, 0, 4'd0);
      checkOutput("rst_quiet");
    end

`ifndef DECODER_SCAN_MODE_EN
    // Without scan support a mode=1 accept is a plain decode.
    applyStimulus(1, 1, 1, 3'd2, 1, 4'd5);
    checkOutput("noscan");
    check("noscan_out", 32'(out_n), 32'hDF);
    check("noscan_busy", 32'(busy), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit               r, e, v, md;
      logic [SEL_W-1:0] s;
      logic [DWELL_W-1:0] dw;
      r  = ($urandom_range(0, 79) != 0);
      e  = ($urandom_range(0, 39) != 0);
      v  = ($urandom_range(0, 2) != 0);
      md = ($urandom_range(0, 3) == 0);
      s  = 3'($urandom_range(0, 7));
      dw = 4'($urandom_range(0, 2));
      applyStimulus(r, e, v, s, md, dw);
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
